// File: rtl/core_bus_bridge.sv
// rtl/core_bus_bridge.sv - Wishbone classic slave to single-access core memory port bridge
// Define BRIDGE_TIMEOUT_EN to build the WAIT-state timeout that ends a stalled access with wb_err_o.
module core_bus_bridge #(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int TIMEOUT_BITS   = 11
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  input  logic        wb_we_i,
  input  logic [31:0] wb_adr_i,
  input  logic [31:0] wb_dat_i,
  input  logic [3:0]  wb_sel_i,
  output logic        wb_ack_o,
  output logic        wb_err_o,
  output logic [31:0] wb_dat_o,
  output logic        mem_read_o,
  output logic        mem_write_o,
  output logic [31:0] mem_address_o,
  output logic [31:0] mem_write_data_o,
  input  logic        mem_response_i,
  input  logic [31:0] mem_read_data_i,
  output logic        busy_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_REQ,
    S_RD_WAIT,
    S_RMW_REQ,
    S_RMW_WAIT,
    S_WR_REQ,
    S_WR_WAIT,
    S_DONE
  } state_t;

  state_t      r_state;
  state_t      w_next_state;
  logic [29:0] r_adr;
  logic [31:0] r_wdata;
  logic [3:0]  r_sel;
  logic [31:0] r_rdata;
  logic        w_req;
  logic        w_timeout;
  logic [31:0] w_merged;
  logic        w_unused_adr;

  assign w_req        = wb_cyc_i & wb_stb_i;
  assign w_unused_adr = ^wb_adr_i[1:0];

  assign mem_address_o    = {r_adr, 2'b00};
  assign mem_write_data_o = r_wdata;
  assign wb_dat_o         = r_rdata;

  // Selected bytes come from the bus, the rest from the word just read back.
  always_comb begin
    w_merged = mem_read_data_i;
    for (int n = 0; n < 4; n++) begin
      if (r_sel[n]) begin
        w_merged[8*n +: 8] = r_wdata[8*n +: 8];
      end
    end
  end

`ifdef BRIDGE_TIMEOUT_EN
  localparam logic [TIMEOUT_BITS-1:0] LP_TMO_LIMIT = TIMEOUT_BITS'(TIMEOUT_CYCLES);

  logic [TIMEOUT_BITS-1:0] r_tmo;
  logic                    w_in_wait;

  assign w_in_wait = (r_state == S_RD_WAIT) | (r_state == S_RMW_WAIT) | (r_state == S_WR_WAIT);
  assign w_timeout = w_in_wait & ~mem_response_i & (r_tmo == LP_TMO_LIMIT);

  // Held at zero outside WAIT states, so every WAIT entry starts a fresh count.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_tmo <= '0;
    end else if (!w_in_wait) begin
      r_tmo <= '0;
    end else if (!w_timeout) begin
      r_tmo <= r_tmo + 1'b1;
    end
  end
`else
  localparam int lp_unused_tmo = TIMEOUT_CYCLES + TIMEOUT_BITS;

  assign w_timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    mem_read_o   = 1'b0;
    mem_write_o  = 1'b0;
    wb_ack_o     = 1'b0;
    wb_err_o     = 1'b0;
    busy_o       = (r_state != S_IDLE);
    case (r_state)
      S_IDLE: begin
        if (w_req) begin
          if (!wb_we_i) begin
            w_next_state = S_RD_REQ;
          end else if (wb_sel_i == 4'hF) begin
            w_next_state = S_WR_REQ;
          end else if (wb_sel_i == 4'h0) begin
            w_next_state = S_DONE;
          end else begin
            w_next_state = S_RMW_REQ;
          end
        end
      end
      S_RD_REQ: begin
        mem_read_o   = 1'b1;
        w_next_state = S_RD_WAIT;
      end
      S_RD_WAIT: begin
        if (mem_response_i) begin
          w_next_state = S_DONE;
        end else if (w_timeout) begin
          wb_err_o     = wb_cyc_i;
          w_next_state = S_IDLE;
        end
      end
      S_RMW_REQ: begin
        mem_read_o   = 1'b1;
        w_next_state = S_RMW_WAIT;
      end
      S_RMW_WAIT: begin
        if (mem_response_i) begin
          w_next_state = S_WR_REQ;
        end else if (w_timeout) begin
          wb_err_o     = wb_cyc_i;
          w_next_state = S_IDLE;
        end
      end
      S_WR_REQ: begin
        mem_write_o  = 1'b1;
        w_next_state = S_WR_WAIT;
      end
      S_WR_WAIT: begin
        if (mem_response_i) begin
          w_next_state = S_DONE;
        end else if (w_timeout) begin
          wb_err_o     = wb_cyc_i;
          w_next_state = S_IDLE;
        end
      end
      S_DONE: begin
        // A master that dropped cyc mid-access gets no ack.
        wb_ack_o     = wb_cyc_i;
        w_next_state = S_IDLE;
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_adr   <= '0;
      r_wdata <= '0;
      r_sel   <= '0;
      r_rdata <= '0;
    end else begin
      if ((r_state == S_IDLE) && w_req) begin
        r_adr   <= wb_adr_i[31:2];
        r_wdata <= wb_dat_i;
        r_sel   <= wb_sel_i;
      end
      if ((r_state == S_RD_WAIT) && mem_response_i) begin
        r_rdata <= mem_read_data_i;
      end
      if ((r_state == S_RMW_WAIT) && mem_response_i) begin
        r_wdata <= w_merged;
      end
    end
  end

endmodule

// File: tb/tb_core_bus_bridge.sv
// tb/tb_core_bus_bridge.sv - randomized self-checking bench for core_bus_bridge against a word-memory model
module tb_core_bus_bridge;
  localparam int TMO = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        wb_cyc_i, wb_stb_i, wb_we_i;
  logic [31:0] wb_adr_i, wb_dat_i;
  logic [3:0]  wb_sel_i;
  logic        wb_ack_o, wb_err_o;
  logic [31:0] wb_dat_o;
  logic        mem_read_o, mem_write_o;
  logic [31:0] mem_address_o, mem_write_data_o;
  logic        mem_response_i;
  logic [31:0] mem_read_data_i;
  logic        busy_o;

  core_bus_bridge #(.TIMEOUT_CYCLES(TMO), .TIMEOUT_BITS(4)) dut (
    .clk(clk), .reset(reset),
    .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i), .wb_we_i(wb_we_i),
    .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i), .wb_sel_i(wb_sel_i),
    .wb_ack_o(wb_ack_o), .wb_err_o(wb_err_o), .wb_dat_o(wb_dat_o),
    .mem_read_o(mem_read_o), .mem_write_o(mem_write_o),
    .mem_address_o(mem_address_o), .mem_write_data_o(mem_write_data_o),
    .mem_response_i(mem_response_i), .mem_read_data_i(mem_read_data_i),
    .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  logic [31:0] bus_mem [64];
  logic [31:0] ref_mem [64];
  logic [31:0] pend_data;
  logic        resp_en = 1'b1;
  int resp_k = 1, pend = 0, cyc_no = 0;
  int n_rd, n_wr, n_ack, n_err, n_busy, tot_err = 0;
  int rd_cyc, wr_cyc, ack_cyc, err_cyc, s_cyc;
  logic        s_busy;
  logic [31:0] rd_adr, wr_adr, wr_dat;

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_w, input logic [31:0] new_w,
                                              input logic [3:0] sel);
    logic [31:0] r;
    r = old_w;
    for (int b = 0; b < 4; b++) if (sel[b]) r[8*b +: 8] = new_w[8*b +: 8];
    return r;
  endfunction

  // Sample the current cycle, advance one clock, then play the memory side for the new cycle.
  task automatic step();
    #1;
    s_busy = busy_o;
    s_cyc  = cyc_no;
    if (busy_o) n_busy++;
    if (mem_read_o) begin
      n_rd++; rd_cyc = cyc_no; rd_adr = mem_address_o;
      pend_data = bus_mem[mem_address_o[7:2]];
      pend = resp_k;
    end
    if (mem_write_o) begin
      n_wr++; wr_cyc = cyc_no; wr_adr = mem_address_o; wr_dat = mem_write_data_o;
      bus_mem[mem_address_o[7:2]] = mem_write_data_o;
      pend = resp_k;
    end
    if (wb_ack_o) begin n_ack++; ack_cyc = cyc_no; end
    if (wb_err_o) begin n_err++; err_cyc = cyc_no; tot_err++; end
    @(posedge clk); #1;
    cyc_no++;
    mem_response_i  = 1'b0;
    mem_read_data_i = $urandom();
    if (pend > 0) begin
      pend--;
      if (pend == 0 && resp_en) begin
        mem_response_i  = 1'b1;
        mem_read_data_i = pend_data;
      end
    end
  endtask

  task automatic clear_stats();
    n_rd = 0; n_wr = 0; n_ack = 0; n_err = 0; n_busy = 0;
    rd_cyc = -1; wr_cyc = -1; ack_cyc = -1; err_cyc = -1;
  endtask

  task automatic run_txn(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                         input logic [3:0] sel, input int k, output int lat);
    int t0;
    int guard;
    clear_stats();
    resp_k = k;
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = we;
    wb_adr_i = adr; wb_dat_i = dat; wb_sel_i = sel;
    t0 = cyc_no;
    guard = 0;
    while (n_ack == 0 && n_err == 0 && guard < 200) begin
      step();
      guard++;
    end
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0; wb_sel_i = 4'h0;
    check_eq("txn_terminates", 32'(guard < 200), 32'd1);
    lat = (ack_cyc >= 0) ? ack_cyc - t0 : err_cyc - t0;
    step();
  endtask

  initial begin
    int lat, t0, guard, k;
    logic [31:0] last_read, dat, adr;
    logic [5:0]  idx;
    logic [3:0]  sel;
    logic        we;
    int          r;

    for (int i = 0; i < 64; i++) begin
      bus_mem[i] = $urandom();
      ref_mem[i] = bus_mem[i];
    end
    reset = 1'b1; wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
    wb_adr_i = '0; wb_dat_i = '0; wb_sel_i = '0;
    mem_response_i = 1'b0; mem_read_data_i = '0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    check_eq("rst_ack", 32'(wb_ack_o), 0);
    check_eq("rst_err", 32'(wb_err_o), 0);
    check_eq("rst_dat", wb_dat_o, 0);
    check_eq("rst_rd", 32'(mem_read_o), 0);
    check_eq("rst_wr", 32'(mem_write_o), 0);
    check_eq("rst_adr", mem_address_o, 0);
    check_eq("rst_wdata", mem_write_data_o, 0);
    check_eq("rst_busy", 32'(busy_o), 0);

    // Directed read at 0x104, memory answers two cycles after the request.
    bus_mem[65 % 64] = 32'hDEADBEEF; ref_mem[65 % 64] = 32'hDEADBEEF;
    run_txn(1'b0, 32'h0000_0104, 32'h0, 4'hF, 2, lat);
    check_eq("rd_adr", rd_adr, 32'h104);
    check_eq("rd_req_cycle", 32'(rd_cyc - (ack_cyc - lat)), 1);
    check_eq("rd_ack_lat", 32'(lat), 4);
    check_eq("rd_data", wb_dat_o, 32'hDEADBEEF);
    check_eq("rd_nwr", 32'(n_wr), 0);
    last_read = 32'hDEADBEEF;

    run_txn(1'b1, 32'h20, 32'h12345678, 4'hF, 1, lat);
    check_eq("wf_nwr", 32'(n_wr), 1);
    check_eq("wf_nrd", 32'(n_rd), 0);
    check_eq("wf_adr", wr_adr, 32'h20);
    check_eq("wf_data", wr_dat, 32'h12345678);
    check_eq("wf_nack", 32'(n_ack), 1);
    ref_mem[8] = 32'h12345678;

    bus_mem[16] = 32'h11223344; ref_mem[16] = 32'h11223344;
    run_txn(1'b1, 32'h40, 32'hAABBCCDD, 4'b0101, 2, lat);
    check_eq("rmw_nrd", 32'(n_rd), 1);
    check_eq("rmw_nwr", 32'(n_wr), 1);
    check_eq("rmw_data", wr_dat, 32'h11BB33DD);
    check_eq("rmw_lat", 32'(lat), 7);
    check_eq("rmw_keeps_dat", wb_dat_o, last_read);
    ref_mem[16] = 32'h11BB33DD;

    run_txn(1'b1, 32'h60, 32'hCAFEF00D, 4'h0, 1, lat);
    check_eq("sel0_noaccess", 32'(n_rd + n_wr), 0);
    check_eq("sel0_lat", 32'(lat >= 1 && lat <= 2), 1);
    check_eq("sel0_nack", 32'(n_ack), 1);

    // cyc dropped while the read is outstanding.
    clear_stats();
    resp_k = 4;
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0; wb_adr_i = 32'h80; wb_sel_i = 4'hF;
    t0 = cyc_no;
    step(); step();
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
    guard = 0;
    do begin step(); guard++; end while (s_busy && guard < 50);
    check_eq("abort_busy_fall", 32'(s_cyc - t0), 7);
    check_eq("abort_nrd", 32'(n_rd), 1);
    check_eq("abort_noack", 32'(n_ack), 0);
    check_eq("abort_dat", wb_dat_o, ref_mem[32]);
    last_read = ref_mem[32];

    // Reset while the write waits for its response.
    clear_stats();
    resp_k = 6;
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b1; wb_adr_i = 32'h44;
    wb_dat_i = 32'h5A5A_0F0F; wb_sel_i = 4'hF;
    step(); step(); step();
    reset = 1'b1; wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
    step();
    reset = 1'b0;
    #1;
    check_eq("rstmid_ack", 32'(wb_ack_o), 0);
    check_eq("rstmid_wr", 32'(mem_write_o), 0);
    check_eq("rstmid_busy", 32'(busy_o), 0);
    check_eq("rstmid_dat", wb_dat_o, 0);
    check_eq("rstmid_adr", mem_address_o, 0);
    check_eq("rstmid_wdata", mem_write_data_o, 0);
    ref_mem[17] = 32'h5A5A_0F0F;
    clear_stats();
    repeat (10) step();
    check_eq("late_resp_ignored", 32'(n_ack + n_busy + n_rd + n_wr), 0);
    last_read = 32'h0;

    for (int i = 0; i < 40; i++) begin
      we  = 1'($urandom_range(0, 1));
      idx = 6'($urandom_range(0, 63));
      dat = $urandom();
      r   = $urandom_range(0, 5);
      sel = (r < 2) ? 4'hF : (r == 2) ? 4'h0 : 4'($urandom_range(1, 14));
      k   = $urandom_range(1, 4);
      adr = {24'h0, idx, 2'($urandom_range(0, 3))};
      run_txn(we, adr, dat, sel, k, lat);
      check_eq("rnd_nack", 32'(n_ack), 1);
      if (!we) begin
        check_eq("rnd_rd_data", wb_dat_o, ref_mem[idx]);
        check_eq("rnd_rd_lat", 32'(lat), 32'(2 + k));
        check_eq("rnd_rd_adr", rd_adr, {adr[31:2], 2'b00});
        check_eq("rnd_rd_cnt", 32'(n_rd * 16 + n_wr), 16);
        last_read = ref_mem[idx];
      end else begin
        if (sel == 4'hF) begin
          check_eq("rnd_wf_cnt", 32'(n_rd * 16 + n_wr), 1);
          check_eq("rnd_wf_lat", 32'(lat), 32'(2 + k));
        end else if (sel == 4'h0) begin
          check_eq("rnd_w0_cnt", 32'(n_rd + n_wr), 0);
        end else begin
          check_eq("rnd_rmw_cnt", 32'(n_rd * 16 + n_wr), 17);
          check_eq("rnd_rmw_lat", 32'(lat), 32'(3 + 2 * k));
        end
        if (sel != 4'h0) begin
          ref_mem[idx] = merge_bytes(ref_mem[idx], dat, sel);
          check_eq("rnd_wr_data", wr_dat, ref_mem[idx]);
          check_eq("rnd_wr_adr", wr_adr, {adr[31:2], 2'b00});
        end
        check_eq("rnd_wr_keeps_dat", wb_dat_o, last_read);
      end
    end

`ifdef BRIDGE_TIMEOUT_EN
    resp_en = 1'b0;
    run_txn(1'b0, 32'h10, 32'h0, 4'hF, 1, lat);
    check_eq("tmo_rd_err", 32'(n_err), 1);
    check_eq("tmo_rd_noack", 32'(n_ack), 0);
    check_eq("tmo_rd_lat", 32'(lat), 32'(2 + TMO));
    run_txn(1'b1, 32'h14, 32'hFFFF_FFFF, 4'b0011, 1, lat);
    check_eq("tmo_rmw_err", 32'(n_err), 1);
    check_eq("tmo_rmw_nowr", 32'(n_wr), 0);
    resp_en = 1'b1;
    run_txn(1'b0, 32'h18, 32'h0, 4'hF, 1, lat);
    check_eq("tmo_recover_data", wb_dat_o, ref_mem[6]);
    check_eq("tmo_recover_ack", 32'(n_ack), 1);
`else
    check_eq("no_err_default", 32'(tot_err), 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
